// File: rtl/nms_window_stage.sv
// Canny non-maximum suppression stage.
// Takes a 3x3 magnitude window and a 3x3 direction window, compares the centre
// magnitude against its two neighbours along the gradient direction, and emits
// the thinned centre magnitude two register stages later.
module nms_window_stage #(
  parameter int MAG_W      = 11,
  parameter int DIR_W      = 2,
  parameter int LOW_THRESH = 0
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [9*MAG_W-1:0]   gradient_magnitude,
  input  logic [9*DIR_W-1:0]   gradient_direction,
  input  logic                 gradient_data_valid,
  output logic [MAG_W-1:0]     nms_magnitude,
  output logic [DIR_W-1:0]     nms_direction,
  output logic                 nms_valid
);

  localparam logic [MAG_W-1:0] LOW_LIMIT = MAG_W'(LOW_THRESH);

  logic [MAG_W-1:0] centre_mag;
  logic [DIR_W-1:0] centre_dir;
  logic [MAG_W-1:0] sel_a;
  logic [MAG_W-1:0] sel_b;

  logic [MAG_W-1:0] s1_c;
  logic [MAG_W-1:0] s1_a;
  logic [MAG_W-1:0] s1_b;
  logic [DIR_W-1:0] s1_d;
  logic             s1_valid;

  logic             keep;

  assign centre_mag = gradient_magnitude[4*MAG_W +: MAG_W];
  assign centre_dir = gradient_direction[4*DIR_W +: DIR_W];

  // Pick the two neighbours lying along the gradient direction of the centre pixel.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    case (centre_dir)
      2'd0: begin
        sel_a = gradient_magnitude[3*MAG_W +: MAG_W];
        sel_b = gradient_magnitude[5*MAG_W +: MAG_W];
      end
      2'd1: begin
        sel_a = gradient_magnitude[2*MAG_W +: MAG_W];
        sel_b = gradient_magnitude[6*MAG_W +: MAG_W];
      end
      2'd2: begin
        sel_a = gradient_magnitude[1*MAG_W +: MAG_W];
        sel_b = gradient_magnitude[7*MAG_W +: MAG_W];
      end
      default: begin
        sel_a = gradient_magnitude[0*MAG_W +: MAG_W];
        sel_b = gradient_magnitude[8*MAG_W +: MAG_W];
      end
    endcase
  end

  // Stage 1: capture centre, direction and the selected neighbour pair.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1_c     <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_d     <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_c     <= centre_mag;
      s1_a     <= sel_a;
      s1_b     <= sel_b;
      s1_d     <= centre_dir;
      s1_valid <= gradient_data_valid;
    end
  end

  // Ties keep the centre so flat ridges survive; weak pixels are always dropped.
  assign keep = (s1_c >= s1_a) && (s1_c >= s1_b) && (s1_c > LOW_LIMIT);

  // Stage 2: register the thinned magnitude, direction and valid.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      nms_magnitude <= '0;
      nms_direction <= '0;
      nms_valid     <= 1'b0;
    end else begin
      nms_magnitude <= keep ? s1_c : '0;
      nms_direction <= s1_d;
      nms_valid     <= s1_valid;
    end
  end

endmodule

// File: tb/tb_nms_window_stage.sv
// Self-checking bench for nms_window_stage: directed windows plus a randomized
// stream, checked against a neighbour-table model of the keep rule. A second
// instance with LOW_THRESH=5 shares the stimulus to exercise the threshold.
module tb_nms_window_stage;

  localparam int MAG_W = 11;
  localparam int DIR_W = 2;

  logic                clk;
  logic                rstN;
  logic [9*MAG_W-1:0]  gradMag;
  logic [9*DIR_W-1:0]  gradDir;
  logic                gradValid;

  logic [MAG_W-1:0]    magOut;
  logic [DIR_W-1:0]    dirOut;
  logic                validOut;
  logic [MAG_W-1:0]    magOutT;
  logic [DIR_W-1:0]    dirOutT;
  logic                validOutT;

  int checkCount;
  int passCount;

  // Expected result of the window sampled at the previous edge.
  logic [MAG_W-1:0]    pendMag;
  logic [MAG_W-1:0]    pendMagT;
  logic [DIR_W-1:0]    pendDir;
  logic                pendValid;
  string               pendTag;

  nms_window_stage #(.MAG_W(MAG_W), .DIR_W(DIR_W), .LOW_THRESH(0)) dut (
    .clk                 (clk),
    .rstN                (rstN),
    .gradient_magnitude  (gradMag),
    .gradient_direction  (gradDir),
    .gradient_data_valid (gradValid),
    .nms_magnitude       (magOut),
    .nms_direction       (dirOut),
    .nms_valid           (validOut)
  );

  nms_window_stage #(.MAG_W(MAG_W), .DIR_W(DIR_W), .LOW_THRESH(5)) dutT (
    .clk                 (clk),
    .rstN                (rstN),
    .gradient_magnitude  (gradMag),
    .gradient_direction  (gradDir),
    .gradient_data_valid (gradValid),
    .nms_magnitude       (magOutT),
    .nms_direction       (dirOutT),
    .nms_valid           (validOutT)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Neighbour pairs indexed by direction code: 0 deg, 45, 90, 135.
  function automatic logic [MAG_W-1:0] nmsModel(input logic [9*MAG_W-1:0] mw,
                                                input logic [DIR_W-1:0] d,
                                                input int thresh);
    int nbrA[4];
    int nbrB[4];
    int c;
    int a;
    int b;
    nbrA = '{3, 2, 1, 0};
    nbrB = '{5, 6, 7, 8};
    c = int'(mw[4*MAG_W +: MAG_W]);
    a = int'(mw[nbrA[d]*MAG_W +: MAG_W]);
    b = int'(mw[nbrB[d]*MAG_W +: MAG_W]);
    if (c >= a && c >= b && c > thresh) return MAG_W'(c);
    return '0;
  endfunction

  function automatic logic [9*MAG_W-1:0] win(input int k0, input int k1, input int k2,
                                             input int k3, input int k4, input int k5,
                                             input int k6, input int k7, input int k8);
    logic [9*MAG_W-1:0] w;
    w = '0;
    w[0*MAG_W +: MAG_W] = MAG_W'(k0);
    w[1*MAG_W +: MAG_W] = MAG_W'(k1);
    w[2*MAG_W +: MAG_W] = MAG_W'(k2);
    w[3*MAG_W +: MAG_W] = MAG_W'(k3);
    w[4*MAG_W +: MAG_W] = MAG_W'(k4);
    w[5*MAG_W +: MAG_W] = MAG_W'(k5);
    w[6*MAG_W +: MAG_W] = MAG_W'(k6);
    w[7*MAG_W +: MAG_W] = MAG_W'(k7);
    w[8*MAG_W +: MAG_W] = MAG_W'(k8);
    return w;
  endfunction

  // Direction window with the wanted centre code and random, unused surroundings.
  function automatic logic [9*DIR_W-1:0] dirWin(input int d);
    logic [9*DIR_W-1:0] w;
    w = 18'($urandom);
    w[4*DIR_W +: DIR_W] = DIR_W'(d);
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic clearPending();
    pendMag   = '0;
    pendMagT  = '0;
    pendDir   = '0;
    pendValid = 1'b0;
    pendTag   = "post_reset";
  endtask

  // Drive one window, clock it in, and check the result of the previous window.
  task automatic applyStimulus(input string tag, input logic [9*MAG_W-1:0] mw,
                               input logic [9*DIR_W-1:0] dw, input logic v);
    logic [MAG_W-1:0] nextMag;
    logic [MAG_W-1:0] nextMagT;
    logic [DIR_W-1:0] nextDir;
    gradMag   = mw;
    gradDir   = dw;
    gradValid = v;
    nextMag   = nmsModel(mw, dw[4*DIR_W +: DIR_W], 0);
    nextMagT  = nmsModel(mw, dw[4*DIR_W +: DIR_W], 5);
    nextDir   = dw[4*DIR_W +: DIR_W];
    @(posedge clk);
    #1;
    checkOutput({pendTag, "_valid"}, 32'(validOut), 32'(pendValid));
    checkOutput({pendTag, "_validT"}, 32'(validOutT), 32'(pendValid));
    if (pendValid) begin
      checkOutput({pendTag, "_mag"}, 32'(magOut), 32'(pendMag));
      checkOutput({pendTag, "_dir"}, 32'(dirOut), 32'(pendDir));
      checkOutput({pendTag, "_magT"}, 32'(magOutT), 32'(pendMagT));
      checkOutput({pendTag, "_dirT"}, 32'(dirOutT), 32'(pendDir));
    end
    pendMag   = nextMag;
    pendMagT  = nextMagT;
    pendDir   = nextDir;
    pendValid = v;
    pendTag   = tag;
  endtask

  task automatic randomWindow(output logic [9*MAG_W-1:0] mw);
    int range;
    range = ($urandom_range(0, 1) == 0) ? 7 : 2047;
    for (int k = 0; k < 9; k++) mw[k*MAG_W +: MAG_W] = MAG_W'($urandom_range(0, range));
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_mag"}, 32'(magOut), 32'd0);
    checkOutput({tag, "_dir"}, 32'(dirOut), 32'd0);
    checkOutput({tag, "_valid"}, 32'(validOut), 32'd0);
    checkOutput({tag, "_validT"}, 32'(validOutT), 32'd0);
  endtask

  // Hold reset for a few edges with live valid traffic, then release between edges.
  task automatic holdReset(input string tag, input int edges);
    logic [9*MAG_W-1:0] mw;
    for (int i = 0; i < edges; i++) begin
      randomWindow(mw);
      gradMag   = mw;
      gradDir   = 18'($urandom);
      gradValid = 1'b1;
      @(posedge clk);
      #1;
      checkCleared(tag);
    end
    rstN = 1'b1;
    clearPending();
  endtask

  initial begin
    logic [9*MAG_W-1:0] mw;
    logic [9*DIR_W-1:0] dw;
    checkCount = 0;
    passCount  = 0;
    gradMag    = '0;
    gradDir    = '0;
    gradValid  = 1'b0;
    rstN       = 1'b0;
    clearPending();
    #3;
    checkCleared("reset_hold");
    holdReset("reset_hold", 3);

    // First valid after release must appear exactly one edge after the next one.
    applyStimulus("first_valid", win(0, 0, 0, 100, 200, 150, 0, 0, 0), dirWin(0), 1'b1);
    applyStimulus("horiz_suppress", win(0, 0, 0, 100, 200, 201, 0, 0, 0), dirWin(0), 1'b1);
    applyStimulus("diag45_keep", win(1000, 0, 50, 0, 60, 0, 59, 0, 1000), dirWin(1), 1'b1);
    applyStimulus("diag135_supp", win(1000, 0, 50, 0, 60, 0, 59, 0, 1000), dirWin(3), 1'b1);
    applyStimulus("vert_tie", win(0, 300, 0, 0, 300, 0, 0, 10, 0), dirWin(2), 1'b1);
    applyStimulus("gap", win(0, 0, 0, 0, 9, 0, 0, 0, 0), dirWin(0), 1'b0);
    applyStimulus("all_five", win(5, 5, 5, 5, 5, 5, 5, 5, 5), dirWin(1), 1'b1);
    applyStimulus("all_zero", win(0, 0, 0, 0, 0, 0, 0, 0, 0), dirWin(2), 1'b1);
    for (int d = 0; d < 4; d++)
      applyStimulus($sformatf("max_d%0d", d),
                    win(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047), dirWin(d), 1'b1);
    applyStimulus("flush", '0, '0, 1'b0);
    applyStimulus("flush", '0, '0, 1'b0);

    // Randomized stream with gaps and a mid-stream reset.
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        rstN = 1'b0;
        #1;
        checkCleared("midreset_async");
        holdReset("midreset_hold", 2);
      end
      randomWindow(mw);
      dw = 18'($urandom);
      applyStimulus("stream", mw, dw, ($urandom_range(0, 3) != 0));
    end
    applyStimulus("drain", '0, '0, 1'b0);
    applyStimulus("drain", '0, '0, 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
